// File: rtl/flappy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : flappy_engine
//  Brief    : Game-logic core for the LED-matrix Flappy Bird. It handles bird
//             movement, scrolling beam columns with LFSR-placed gaps,
//             collision detection, a saturating score and the IDLE/RUN/OVER
//             game state.
//  Options  : FLAPPY_GRAVITY_EN - when defined, the bird drops one row on
//             scroll ticks where no button is pressed.
//  Revision : 1.0 - initial release
// ============================================================================
module flappy_engine #(
  parameter int GS      = 8,
  parameter int CR      = 2,
  parameter int SPACING = 4,
  parameter int GAP     = 2,
  parameter int SCORE_W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               e_act_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [GS*GS-1:0]   matrix_o,
  output logic               d_act_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [1:0]         state_o
);

  localparam int                 c_RW        = $clog2(GS);
  localparam int                 c_SW        = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int                 c_N         = GS * GS;
  localparam logic [c_RW-1:0]    c_ROW_TOP   = c_RW'(GS - 1);
  localparam logic [c_RW-1:0]    c_ROW_MID   = c_RW'(GS / 2);
  localparam logic [c_SW-1:0]    c_SPC_LAST  = c_SW'(SPACING - 1);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_RW-1:0]    r_row, w_row_nxt;
  logic [c_N-1:0]     r_beams, w_beams_nxt;
  logic [CR-1:0]      r_div, w_div_nxt;
  logic [c_SW-1:0]    r_spc, w_spc_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [c_N-1:0]     r_matrix, w_matrix_nxt;
  logic               r_dact;
  logic [7:0]         r_lfsr;
  logic [GS-1:0]      w_new_beam;
  logic [GS-1:0]      w_bird;
  logic [c_N-1:0]     w_diag;
  logic               w_die;
  logic               w_scored;

  assign matrix_o = r_matrix;
  assign d_act_o  = r_dact;
  assign score_o  = r_score;
  assign state_o  = r_state;

  // Beam column for the next insertion: solid except a GAP-row hole placed by the LFSR
  always_comb begin
    int v_r;
    int v_lo;
    v_r        = int'(r_lfsr[c_RW-1:0]);
    v_lo       = (v_r <= GS - GAP) ? v_r : v_r - (GS - GAP + 1);
    w_new_beam = '1;
    for (int i = 0; i < GS; i++) begin
      if (i >= v_lo && i < v_lo + GAP) w_new_beam[i] = 1'b0;
    end
  end

  // Attract-mode frame shown on idle ticks
  always_comb begin
    w_diag = '0;
    for (int c = 0; c < GS; c++) w_diag[c*GS + c] = 1'b1;
  end

  // Next-state and next-frame logic; everything is judged on the pre-tick state
  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_beams_nxt  = r_beams;
    w_div_nxt    = r_div;
    w_spc_nxt    = r_spc;
    w_score_nxt  = r_score;
    w_matrix_nxt = r_matrix;
    w_die        = 1'b0;
    w_scored     = 1'b0;
    w_bird       = '0;
    if (e_act_i) begin
      case (r_state)
        S_RUN: begin
          if (up_i) begin
            if (r_row == c_ROW_TOP) w_die = 1'b1;
            else                    w_row_nxt = r_row + 1'b1;
          end else if (down_i) begin
            if (r_row == '0) w_die = 1'b1;
            else             w_row_nxt = r_row - 1'b1;
          end
`ifdef FLAPPY_GRAVITY_EN
          else if (r_div == '0) begin
            if (r_row == '0) w_die = 1'b1;
            else             w_row_nxt = r_row - 1'b1;
          end
`endif
          if (r_div == '0) begin
            w_scored    = |r_beams[GS-1:0];
            w_beams_nxt = {((r_spc == '0) ? w_new_beam : {GS{1'b0}}), r_beams[c_N-1:GS]};
            w_spc_nxt   = (r_spc == c_SPC_LAST) ? '0 : r_spc + 1'b1;
          end
          w_div_nxt = r_div + 1'b1;
          w_bird    = GS'(1) << w_row_nxt;
          if ((w_beams_nxt[GS-1:0] & w_bird) != '0) w_die = 1'b1;
          if (w_scored && !w_die && (r_score != c_SCORE_MAX)) w_score_nxt = r_score + 1'b1;
          if (w_die) w_state_nxt = S_OVER;
          w_matrix_nxt = {w_beams_nxt[c_N-1:GS], w_beams_nxt[GS-1:0] | w_bird};
        end
        default: begin
          // IDLE and OVER: up starts a fresh game, nothing moves on that tick
          if (up_i) begin
            w_state_nxt  = S_RUN;
            w_row_nxt    = c_ROW_MID;
            w_beams_nxt  = '0;
            w_div_nxt    = '0;
            w_spc_nxt    = '0;
            w_score_nxt  = '0;
            w_bird       = GS'(1) << c_ROW_MID;
            w_matrix_nxt = {{(c_N-GS){1'b0}}, w_bird};
          end else if (r_state == S_IDLE) begin
            w_matrix_nxt = w_diag;
          end
        end
      endcase
    end
  end

  // Game state registers; the frame strobe follows every tick by one cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_row    <= c_ROW_MID;
      r_beams  <= '0;
      r_div    <= '0;
      r_spc    <= '0;
      r_score  <= '0;
      r_matrix <= '0;
      r_dact   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_beams  <= w_beams_nxt;
      r_div    <= w_div_nxt;
      r_spc    <= w_spc_nxt;
      r_score  <= w_score_nxt;
      r_matrix <= w_matrix_nxt;
      r_dact   <= e_act_i;
    end
  end

  // Free-running gap LFSR, x^8+x^6+x^5+x^4+1, advances every clock
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_lfsr <= 8'h01;
    else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

endmodule
`default_nettype wire

// File: tb/tb_flappy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flappy_engine
//  Brief    : Self-checking bench for flappy_engine (GS=8, CR=2, SPACING=4,
//             GAP=2) plus a SCORE_W=2, GAP=6 instance for score saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flappy_engine;

  logic        clk     = 1'b0;
  logic        reset_i = 1'b0;
  logic        e_act_i = 1'b0, up_i = 1'b0, down_i = 1'b0;
  logic [63:0] matrix_o;
  logic        d_act_o;
  logic [7:0]  score_o;
  logic [1:0]  state_o;

  logic        s_tick = 1'b0, s_up = 1'b0, s_down = 1'b0;
  logic [63:0] s_matrix;
  logic        s_dact;
  logic [1:0]  s_score;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  flappy_engine #(.GS(8), .CR(2), .SPACING(4), .GAP(2), .SCORE_W(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .e_act_i(e_act_i), .up_i(up_i), .down_i(down_i),
    .matrix_o(matrix_o), .d_act_o(d_act_o), .score_o(score_o), .state_o(state_o));

  flappy_engine #(.GS(8), .CR(2), .SPACING(4), .GAP(6), .SCORE_W(2)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .e_act_i(s_tick), .up_i(s_up), .down_i(s_down),
    .matrix_o(s_matrix), .d_act_o(s_dact), .score_o(s_score), .state_o(s_state));

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_lfsr;
  int          m_state, m_row, m_div, m_spc, m_score;
  logic [7:0]  m_col [8];
  logic [63:0] m_matrix;

  typedef struct {
    logic [63:0] mat;
    logic [1:0]  st;
    logic [7:0]  sc;
    logic        d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         tick;
    bit         up;
    bit         down;
    logic [1:0] st;
    logic       d;
    logic [7:0] col0;
  } vec_t;
  vec_t tbl[9];

  // model LFSR follows the same clock and reset as the DUT
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) m_lfsr <= 8'h01;
    else         m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] beam_of(input logic [7:0] l);
    int r, lo;
    logic [7:0] col;
    r   = int'(l[2:0]);
    lo  = (r <= 6) ? r : r - 7;
    col = 8'hFF;
    for (int k = 0; k < 2; k++) col[lo + k] = 1'b0;
    return col;
  endfunction

  task automatic model_reset();
    m_state = 0; m_row = 4; m_div = 0; m_spc = 0; m_score = 0;
    for (int c = 0; c < 8; c++) m_col[c] = 8'h00;
    m_matrix = 64'h0;
  endtask

  task automatic model_pack();
    for (int c = 0; c < 8; c++) m_matrix[c*8 +: 8] = m_col[c];
    m_matrix[7:0] = m_col[0] | (8'h01 << m_row);
  endtask

  task automatic model_tick(input bit up, input bit down);
    int  nr;
    bit  dead, sc;
    if (m_state != 1) begin
      if (up) begin
        model_reset();
        m_state = 1;
        model_pack();
      end else if (m_state == 0) begin
        m_matrix = 64'h8040201008040201;
      end
    end else begin
      nr = m_row; dead = 0; sc = 0;
      if (up) begin
        if (m_row == 7) dead = 1; else nr = m_row + 1;
      end else if (down) begin
        if (m_row == 0) dead = 1; else nr = m_row - 1;
      end
`ifdef FLAPPY_GRAVITY_EN
      else if (m_div == 0) begin
        if (m_row == 0) dead = 1; else nr = m_row - 1;
      end
`endif
      if (m_div == 0) begin
        sc = (m_col[0] != 8'h00);
        for (int c = 0; c < 7; c++) m_col[c] = m_col[c+1];
        m_col[7] = (m_spc == 0) ? beam_of(m_lfsr) : 8'h00;
        m_spc = (m_spc + 1) % 4;
      end
      m_div = (m_div + 1) % 4;
      if (m_col[0][nr]) dead = 1;
      m_row = nr;
      if (sc && !dead && m_score < 255) m_score++;
      if (dead) m_state = 2;
      model_pack();
    end
  endtask

  // drive one cycle, push the model's expectation, compare after the edge
  task automatic do_cycle(input bit tick, input bit up, input bit down);
    exp_t e, g;
    e_act_i = tick; up_i = up; down_i = down;
    if (tick) model_tick(up, down);
    e.mat = m_matrix; e.st = 2'(m_state); e.sc = 8'(m_score); e.d = tick;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    check("sb_matrix", matrix_o, g.mat);
    check("sb_state", 64'(state_o), 64'(g.st));
    check("sb_score", 64'(score_o), 64'(g.sc));
    check("sb_dact", 64'(d_act_o), 64'(g.d));
    e_act_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
  endtask

  task automatic steer(input int tgt);
    do_cycle(1'b1, m_row < tgt, m_row > tgt);
  endtask

  task automatic do_reset();
    #2 reset_i = 1'b1;
    #1;
    check("rst_matrix", matrix_o, 64'h0);
    check("rst_state", 64'(state_o), 64'h0);
    check("rst_score", 64'(score_o), 64'h0);
    check("rst_dact", 64'(d_act_o), 64'h0);
    model_reset();
    @(negedge clk); reset_i = 1'b0;
  endtask

  initial begin
    int gap_lo, tgt, wall, srow;
    bit su, sd;

    tbl[0] = '{1, 0, 0, 2'b00, 1'b1, 8'h01};
    tbl[1] = '{0, 0, 0, 2'b00, 1'b0, 8'h01};
    tbl[2] = '{1, 1, 0, 2'b01, 1'b1, 8'h10};
    tbl[3] = '{1, 1, 0, 2'b01, 1'b1, 8'h20};
    tbl[4] = '{1, 1, 0, 2'b01, 1'b1, 8'h40};
    tbl[5] = '{1, 1, 0, 2'b01, 1'b1, 8'h80};
    tbl[6] = '{1, 1, 0, 2'b10, 1'b1, 8'h80};
    tbl[7] = '{1, 0, 0, 2'b10, 1'b1, 8'h80};
    tbl[8] = '{0, 0, 0, 2'b10, 1'b0, 8'h80};

    do_reset();

    // idle diagonal, start, climb to the ceiling and die
    for (int i = 0; i < 9; i++) begin
      do_cycle(tbl[i].tick, tbl[i].up, tbl[i].down);
      check($sformatf("vec%0d_state", i), 64'(state_o), 64'(tbl[i].st));
      check($sformatf("vec%0d_dact", i), 64'(d_act_o), 64'(tbl[i].d));
      check($sformatf("vec%0d_col0", i), 64'(matrix_o[7:0]), 64'(tbl[i].col0));
      if (i == 0) check("idle_diag", matrix_o, 64'h8040201008040201);
    end

    // restart from OVER and fly through the first beam's gap
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);
    gap_lo = 0;
    for (int r = 7; r >= 0; r--) if (!m_col[7][r]) gap_lo = r;
`ifdef FLAPPY_GRAVITY_EN
    tgt = gap_lo + 1;
`else
    tgt = gap_lo;
`endif
    for (int t = 1; t <= 32; t++) begin
      steer(tgt);
      if (t == 28) check("gap_alive_t28", 64'(state_o), 64'h1);
      if (t == 32) begin
        check("gap_alive_t32", 64'(state_o), 64'h1);
        check("gap_score_t32", 64'(score_o), 64'h1);
      end
    end

    // asynchronous reset in the middle of a running game
    do_reset();
    do_cycle(1'b1, 1'b0, 1'b0);
    check("post_rst_idle", 64'(state_o), 64'h0);
    check("post_rst_diag", matrix_o, 64'h8040201008040201);

`ifndef FLAPPY_GRAVITY_EN
    // steer into the wall of the first beam
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);
    wall = -1;
    if (m_col[7][4]) wall = 4;
    else for (int r = 7; r >= 0; r--) if (m_col[7][r]) wall = r;
    for (int t = 1; t <= 28; t++) begin
      steer(wall);
      if (t == 27) check("wall_run_t27", 64'(state_o), 64'h1);
      if (t == 28) begin
        check("wall_over_t28", 64'(state_o), 64'h2);
        check("wall_score", 64'(score_o), 64'h0);
      end
    end
    do_cycle(1'b1, 1'b0, 1'b0);
    check("over_hold", 64'(state_o), 64'h2);
`endif

    // no buttons: gravity drop or hold
    do_cycle(1'b1, 1'b1, 1'b0);
`ifdef FLAPPY_GRAVITY_EN
    for (int t = 0; t <= 16; t++) begin
      do_cycle(1'b1, 1'b0, 1'b0);
      if (t % 4 == 0 && t < 16) check($sformatf("grav_row_t%0d", t), 64'(matrix_o[7:0]), 64'(8'h08 >> (t / 4)));
      if (t == 15) check("grav_run_t15", 64'(state_o), 64'h1);
      if (t == 16) check("grav_over_t16", 64'(state_o), 64'h2);
    end
`else
    for (int t = 0; t <= 27; t++) begin
      do_cycle(1'b1, 1'b0, 1'b0);
      if (t == 0 || t == 13 || t == 27) check($sformatf("hold_row_t%0d", t), 64'(matrix_o[7:0]), 64'h10);
      if (t == 27) check("hold_run_t27", 64'(state_o), 64'h1);
    end
`endif

    // score saturation on the SCORE_W=2 instance
    @(negedge clk);
    s_tick = 1'b1; s_up = 1'b1; s_down = 1'b0;
    @(posedge clk); #1;
    check("sat_start", 64'(s_state), 64'h1);
    srow = 4;
    for (int t = 0; t < 100; t++) begin
`ifdef FLAPPY_GRAVITY_EN
      su = (srow < 5); sd = (srow > 5);
`else
      su = (srow < 4); sd = (srow > 4);
`endif
      s_tick = 1'b1; s_up = su; s_down = sd;
      @(posedge clk); #1;
      if (su) srow++;
      else if (sd) srow--;
`ifdef FLAPPY_GRAVITY_EN
      else if (t % 4 == 0) srow--;
`endif
      if (t == 59) check("sat_score_t59", 64'(s_score), 64'h2);
      if (t == 79) check("sat_score_t79", 64'(s_score), 64'h3);
      if (t == 99) begin
        check("sat_score_t99", 64'(s_score), 64'h3);
        check("sat_run_t99", 64'(s_state), 64'h1);
      end
    end
    s_tick = 1'b0; s_up = 1'b0; s_down = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flappy_engine.md
# flappy_engine

Parametrised game-logic core for the LED-matrix Flappy Bird: bird movement, scrolling beam columns with random gaps, collision detection, score counting and game state. It is the generalised successor of the fixed 8×8 action block: grid size, scroll rate, beam spacing and gap height are configurable, and it adds an LFSR gap generator, a saturating score and a game-over state. It sits between the button debouncers and the matrix display driver. `matrix_o` is consumed when `d_act_o` pulses.

## Interface
- `GS`, 8: grid side in LEDs, 4..16.
- `CR`, 2: scroll divider width; columns shift once every 2^CR ticks.
- `SPACING`, 4: shifts between beam insertions, ≥1.
- `GAP`, 2: gap height in rows, 1..GS-2.
- `SCORE_W`, 8: score width.

Ports:
- `clk_i`  in  1: single clock.
- `reset_i`  in  1: asynchronous, active-high reset.
- `e_act_i`  in  1: game tick; every cycle it is high is one tick.
- `up_i`  in  1: move up (toward row GS-1); sampled on ticks only.
- `down_i`  in  1: move down (toward row 0); sampled on ticks only.
- `matrix_o`  out  GS*GS: frame. Column c is bits [c*GS +: GS], bit r is row r. Column 0 is the bird column.
- `d_act_o`  out  1: one-cycle pulse meaning "frame updated".
- `score_o`  out  SCORE_W: beams passed, saturating.
- `state_o`  out  2: 00 IDLE, 01 RUN, 10 OVER.

## Operation
- State machine: IDLE -(tick & up_i)-> RUN -(death)-> OVER -(tick & up_i)-> RUN. There is no other exit from IDLE.
- Start (tick with up_i in IDLE or OVER) performs initialisation only; that tick does no movement and no scroll.
  - Bird row = GS/2; all beam columns = 0.
  - Divider and spacing counters = 0; score = 0.
  - state = RUN; `matrix_o` = bird only.
- IDLE tick without up_i: `matrix_o` = diagonal (bit c*GS+c set for every c).
- OVER: `matrix_o` and `score_o` are frozen at the death frame; ticks without up_i do nothing.
- RUN tick, evaluated on the pre-tick state:
  - Bird: up_i has priority over down_i. Up at row GS-1 → death. Down at row 0 → death. Otherwise move one row.
  - Scroll happens when the divider counter == 0:
    - Column c takes column c+1.
    - Column GS-1 takes a new beam if the spacing counter == 0, else 0.
    - The spacing counter increments and wraps at SPACING-1.
  - The divider counter (CR bits) increments every RUN tick, wrapping naturally.
  - Beam column: all ones except rows gap_lo..gap_lo+GAP-1.
    - r = lfsr[$clog2(GS)-1:0].
    - gap_lo = r if r ≤ GS-GAP, else r-(GS-GAP+1).
  - Collision: post-tick bird row bit set in post-tick column 0 → death.
  - Score: +1 when a scroll removes a non-zero column 0 and the tick causes no death. Holds at 2^SCORE_W-1.
  - Death: state = OVER; the death frame is still displayed.
- `matrix_o` column 0 = beam column 0 OR one-hot(bird row). Other columns = beam columns.
- LFSR: 8 bits, taps x^8+x^6+x^5+x^4+1, shifts every clock in every state. A new beam samples the pre-edge value.

## Timing
- Reset, asynchronous and immediate, no clock needed:
  - state IDLE; `matrix_o` = 0; `d_act_o` = 0; `score_o` = 0.
  - Bird row GS/2; all counters 0; lfsr = 8'h01.
- All outputs are registered and update on the edge that samples the tick. `d_act_o` is high for the cycle following every tick, in every state.
- Back-to-back ticks (`e_act_i` held high) are each processed. `d_act_o` then stays high.
- Non-tick cycles: only the LFSR advances.
- With CR=2, SPACING=4, the beam inserted at RUN tick 0:
  - reaches column 0 at RUN tick 28 (collision checked);
  - is removed, scoring, at RUN tick 32.
- Reset asserted mid-game aborts immediately; the next tick sees IDLE.

## Configuration
- `FLAPPY_GRAVITY_EN` defined: on RUN ticks where the divider counter == 0 and neither button is pressed, the bird drops one row. A drop from row 0 is a death.
- Not defined: with no button pressed, the bird holds its row.

## Test plan
(GS=8, CR=2, SPACING=4, GAP=2 unless stated.)
- Reset mid-RUN, no clock → `matrix_o`=0, `state_o`=00, `score_o`=0, `d_act_o`=0 at once.
- IDLE tick without up → `matrix_o`=64'h8040201008040201 and `d_act_o` high exactly one cycle.
- Start, then up on every tick → rows 5, 6, 7; the 4th tick gives `state_o`=10 with the frame frozen.
- Start; read gap rows from column 7 after RUN tick 0 and steer into the gap → alive at tick 28, `score_o`=1 after tick 32. Steer into the wall instead → OVER at tick 28, `score_o`=0.
- `FLAPPY_GRAVITY_EN`, no buttons → row 3, 2, 1, 0 at ticks 0, 4, 8, 12; OVER at tick 16. Without the macro → row 4 held until tick 28.
- SCORE_W=2, GAP=GS-2 with bird steered through gaps → `score_o` saturates at 3 while play continues.
